// File: rtl/memory_pkg.sv
// Shared types and helpers for the banked on-chip memory and its store buffer.
package memory_pkg;

  // Widest configuration the store-buffer entry has to carry (64-bit words, 8 byte banks).
  localparam int ADDR_W_MAX = 32;
  localparam int MAX_DATA_W = 64;
  localparam int MAX_BANKS  = MAX_DATA_W / 8;

  // Default configuration: 4 KiB of 32-bit words.
  localparam int BANKS = 4;
  localparam int AW    = 12;
  localparam int WAW   = AW - $clog2(BANKS);

  // One queued store. Narrower configurations zero-fill the unused upper bits.
  typedef struct packed {
    logic [ADDR_W_MAX-1:0] waddr;
    logic [MAX_DATA_W-1:0] data;
    logic [MAX_BANKS-1:0]  strb;
  } store_entry_t;

  // Byte address to word address: drop the byte-lane bits.
  function automatic logic [ADDR_W_MAX-1:0] word_addr(input logic [ADDR_W_MAX-1:0] byte_addr,
                                                      input int unsigned        lane_bits);
    return byte_addr >> lane_bits;
  endfunction

endpackage

// File: rtl/memory_bank.sv
// One byte-wide bank: port A read or write (data channel), port B read-only (fetch).
module memory_bank #(
  parameter int    DEPTH          = 1024,
  parameter int    BANK_INDEX     = 0,
  parameter string INIT_FILE_PATH = ""
) (
  input  logic                     clk,
  input  logic                     a_en,
  input  logic                     a_we,
  input  logic [$clog2(DEPTH)-1:0] a_addr,
  input  logic [7:0]               a_wdata,
  output logic [7:0]               a_rdata,
  input  logic                     b_en,
  input  logic [$clog2(DEPTH)-1:0] b_addr,
  output logic [7:0]               b_rdata
);

  // No preload path in this build; the bank tag and init prefix are kept so
  // instantiations stay compatible with preloaded variants.
  localparam int unused_bank_index = BANK_INDEX;
  localparam bit unused_init_empty = (INIT_FILE_PATH == "");

  logic [7:0] mem [DEPTH];

  // Port A: write when enabled with we, otherwise registered read.
  always_ff @(posedge clk) begin
    if (a_en) begin
      if (a_we) begin
        mem[a_addr] <= a_wdata;
      end else begin
        a_rdata <= mem[a_addr];
      end
    end
  end

  // Port B: registered read for instruction fetch.
  always_ff @(posedge clk) begin
    if (b_en) begin
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store FIFO with an associative word-address lookup across valid entries.
module store_buffer
  import memory_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  store_entry_t          push_entry,
  input  logic                  pop,
  output store_entry_t          head,
  output logic                  full,
  output logic                  empty,
  input  logic [ADDR_W_MAX-1:0] lookup_addr,
  output logic                  match
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  store_entry_t  entries [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // Pointers carry a wrap bit so full and empty are distinguishable with equal indices.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = entries[rd_ptr[IW-1:0]];

  // Pointer update; reset discards every queued store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage captures address, data and strobes on push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      entries[wr_ptr[IW-1:0]] <= push_entry;
    end
  end

  // An entry is live when its distance from the read index is below the occupancy.
  always_comb begin
    logic [IW-1:0] offset;
    match  = 1'b0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = IW'(i) - rd_ptr[IW-1:0];
      if (({1'b0, offset} < count) && (entries[i].waddr == lookup_addr)) begin
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/banked_on_chip_memory.sv
// Dual-port banked memory: port A load/store with a store FIFO, port B instruction fetch.
module banked_on_chip_memory
  import memory_pkg::*;
#(
  parameter int    MEMORY_SIZE        = 4096,
  parameter int    DATA_WIDTH         = 32,
  parameter int    STORE_BUFFER_DEPTH = 4,
  parameter string INIT_FILE_PATH     = ""
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           store_i,
  input  logic [$clog2(MEMORY_SIZE)-1:0] store_address_i,
  input  logic [DATA_WIDTH-1:0]          store_data_i,
  input  logic [DATA_WIDTH/8-1:0]        store_width_i,
  output logic                           store_ready_o,
  output logic                           store_done_o,
  input  logic                           load_i,
  input  logic [$clog2(MEMORY_SIZE)-1:0] load_address_i,
  input  logic                           load_invalid_i,
  output logic                           load_ready_o,
  output logic [DATA_WIDTH-1:0]          load_data_o,
  output logic                           load_done_o,
  input  logic                           fetch_i,
  input  logic                           invalidate_i,
  input  logic [$clog2(MEMORY_SIZE)-1:0] fetch_address_i,
  output logic [DATA_WIDTH-1:0]          instruction_o,
  output logic                           fetch_done_o
);

  localparam int BANK_CNT   = DATA_WIDTH / 8;
  localparam int ADDR_W     = $clog2(MEMORY_SIZE);
  localparam int LANE_BITS  = $clog2(BANK_CNT);
  localparam int WORD_AW    = ADDR_W - LANE_BITS;
  localparam int BANK_DEPTH = MEMORY_SIZE / BANK_CNT;

  logic                  load;
  logic                  hit;
  logic                  full;
  logic                  empty;
  logic                  do_load;
  logic                  do_pop;
  logic                  do_bypass;
  logic                  do_push;
  logic                  do_write;
  logic [ADDR_W_MAX-1:0] load_word;
  logic [ADDR_W_MAX-1:0] store_word;
  logic [ADDR_W_MAX-1:0] fetch_word;
  logic [ADDR_W_MAX-1:0] write_word;
  logic [DATA_WIDTH-1:0] write_data;
  logic [BANK_CNT-1:0]   write_strb;
  logic [WORD_AW-1:0]    port_a_addr;
  store_entry_t          push_entry;
  store_entry_t          head;
  logic [DATA_WIDTH-1:0] bank_a_rdata;
  logic [DATA_WIDTH-1:0] bank_b_rdata;
  logic                  store_done_q;
  logic                  load_done_q;
  logic                  fetch_q;
  logic                  unused_bits;

  // Addresses wrap by truncation; byte-lane bits are dropped here.
  assign load_word  = word_addr(ADDR_W_MAX'(load_address_i), LANE_BITS);
  assign store_word = word_addr(ADDR_W_MAX'(store_address_i), LANE_BITS);
  assign fetch_word = word_addr(ADDR_W_MAX'(fetch_address_i), LANE_BITS);

  // Port A arbitration: unblocked load first, then FIFO drain, then direct store bypass.
  always_comb begin
    load      = load_i && !load_invalid_i;
    do_load   = load && !hit;
    do_pop    = !do_load && !empty;
    do_bypass = store_i && empty && !load;
    do_write  = do_pop || do_bypass;
    do_push   = store_i && !full && !do_bypass;
  end

  // Write source and port A address: FIFO head when draining, request inputs when bypassing.
  always_comb begin
    write_word = store_word;
    write_data = store_data_i;
    write_strb = store_width_i;
    if (do_pop) begin
      write_word = head.waddr;
      write_data = head.data[DATA_WIDTH-1:0];
      write_strb = head.strb[BANK_CNT-1:0];
    end
    port_a_addr = do_load ? load_word[WORD_AW-1:0] : write_word[WORD_AW-1:0];
  end

  // Entry pushed for accepted, non-bypassed stores; upper bits zero for narrow configs.
  always_comb begin
    push_entry = '0;
    push_entry.waddr = store_word;
    push_entry.data[DATA_WIDTH-1:0] = store_data_i;
    push_entry.strb[BANK_CNT-1:0] = store_width_i;
  end

  // Upper entry bits and dropped address bits have no consumer in narrow configurations.
  assign unused_bits = ^{head, load_word, store_word, fetch_word, write_word};

  store_buffer #(
    .DEPTH(STORE_BUFFER_DEPTH)
  ) u_store_buffer (
    .clk        (clk_i),
    .rst_n      (rst_n_i),
    .push       (do_push),
    .push_entry (push_entry),
    .pop        (do_pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .lookup_addr(load_word),
    .match      (hit)
  );

  for (genvar i = 0; i < BANK_CNT; i++) begin : g_bank
    memory_bank #(
      .DEPTH         (BANK_DEPTH),
      .BANK_INDEX    (i),
      .INIT_FILE_PATH(INIT_FILE_PATH)
    ) u_bank (
      .clk    (clk_i),
      .a_en   (do_load || (do_write && write_strb[i])),
      .a_we   (do_write),
      .a_addr (port_a_addr),
      .a_wdata(write_data[8*i +: 8]),
      .a_rdata(bank_a_rdata[8*i +: 8]),
      .b_en   (fetch_i),
      .b_addr (fetch_word[WORD_AW-1:0]),
      .b_rdata(bank_b_rdata[8*i +: 8])
    );
  end

  // Completion flags, one cycle after the array access that produced them.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      store_done_q <= 1'b0;
      load_done_q  <= 1'b0;
      fetch_q      <= 1'b0;
    end else begin
      store_done_q <= do_write;
      load_done_q  <= do_load;
      fetch_q      <= fetch_i;
    end
  end

  assign store_ready_o = !full;
  assign load_ready_o  = !hit;
  assign store_done_o  = store_done_q;
  assign load_done_o   = load_done_q;
  assign load_data_o   = bank_a_rdata;
  assign instruction_o = bank_b_rdata;
  assign fetch_done_o  = fetch_q && !invalidate_i;

endmodule

// File: tb/tb_banked_on_chip_memory.sv
// Directed bench for banked_on_chip_memory: store/load table plus multi-cycle sequences.
module tb_banked_on_chip_memory;

  logic        clk;
  logic        rst_n;
  logic        store_i;
  logic [11:0] store_address;
  logic [31:0] store_data;
  logic [3:0]  store_width;
  logic        store_ready;
  logic        store_done;
  logic        load_i;
  logic [11:0] load_address;
  logic        load_invalid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_done;
  logic        fetch_i;
  logic        invalidate;
  logic [11:0] fetch_address;
  logic [31:0] instruction;
  logic        fetch_done;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] expect_val;
  } vec_t;

  vec_t vecs [12];

  banked_on_chip_memory dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .store_i        (store_i),
    .store_address_i(store_address),
    .store_data_i   (store_data),
    .store_width_i  (store_width),
    .store_ready_o  (store_ready),
    .store_done_o   (store_done),
    .load_i         (load_i),
    .load_address_i (load_address),
    .load_invalid_i (load_invalid),
    .load_ready_o   (load_ready),
    .load_data_o    (load_data),
    .load_done_o    (load_done),
    .fetch_i        (fetch_i),
    .invalidate_i   (invalidate),
    .fetch_address_i(fetch_address),
    .instruction_o  (instruction),
    .fetch_done_o   (fetch_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, fails=%0d", fails);
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue a load, waiting (bounded) while it is held off by a queued store.
  task automatic do_load(input logic [11:0] addr, output logic [31:0] data, output logic done);
    int n;
    n = 0;
    load_i       = 1'b1;
    load_address = addr;
    #1;
    while (!load_ready && n < 20) begin
      tick();
      #1;
      n++;
    end
    check("load_ready_wait", load_ready, 1);
    tick();
    done   = load_done;
    data   = load_data;
    load_i = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        dn;
    int          done_cnt;
    int          n;

    vecs[0]  = '{12'h000, 32'h00C0FFEE, 4'hF, 32'h00C0FFEE};
    vecs[1]  = '{12'h010, 32'h5555AAAA, 4'hF, 32'h5555AAAA};
    vecs[2]  = '{12'h040, 32'h0BADF00D, 4'hF, 32'h0BADF00D};
    vecs[3]  = '{12'h080, 32'h12345678, 4'hF, 32'h12345678};
    vecs[4]  = '{12'h200, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF};
    vecs[5]  = '{12'h200, 32'h0000AB00, 4'h2, 32'hFFFFABFF};
    vecs[6]  = '{12'h200, 32'h12345678, 4'h0, 32'hFFFFABFF};
    vecs[7]  = '{12'h204, 32'h01020304, 4'hF, 32'h01020304};
    vecs[8]  = '{12'h206, 32'hAABBCCDD, 4'hC, 32'hAABB0304};
    vecs[9]  = '{12'h300, 32'h33333333, 4'hF, 32'h33333333};
    vecs[10] = '{12'hFFC, 32'h87654321, 4'hF, 32'h87654321};
    vecs[11] = '{12'h201, 32'h00990000, 4'h4, 32'hFF99ABFF};

    rst_n = 1'b1; store_i = 0; store_address = 0; store_data = 0; store_width = 0;
    load_i = 0; load_address = 0; load_invalid = 0; fetch_i = 0; invalidate = 0; fetch_address = 0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_store_ready", store_ready, 1);
    check("reset_load_ready", load_ready, 1);
    check("reset_store_done", store_done, 0);
    check("reset_load_done", load_done, 0);
    check("reset_fetch_done", fetch_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Bypass store then read back.
    store_i = 1; store_address = 12'h100; store_data = 32'hDEADBEEF; store_width = 4'hF;
    #1 check("bypass_ready", store_ready, 1);
    tick();
    store_i = 0;
    check("bypass_done", store_done, 1);
    load_i = 1; load_address = 12'h100;
    tick();
    load_i = 0;
    check("bypass_load_done", load_done, 1);
    check("bypass_load_data", load_data, 32'hDEADBEEF);
    tick();
    check("load_done_pulse", load_done, 0);
    check("store_done_pulse", store_done, 0);

    // Table: each row is a bypassed store followed by a read-back.
    for (int i = 0; i < 12; i++) begin
      store_i = 1; store_address = vecs[i].addr; store_data = vecs[i].data; store_width = vecs[i].strb;
      #1 check($sformatf("vec%0d_store_ready", i), store_ready, 1);
      tick();
      store_i = 0;
      check($sformatf("vec%0d_store_done", i), store_done, 1);
      check($sformatf("vec%0d_no_load_done", i), load_done, 0);
      load_i = 1; load_address = vecs[i].addr;
      #1 check($sformatf("vec%0d_load_ready", i), load_ready, 1);
      tick();
      load_i = 0;
      check($sformatf("vec%0d_load_done", i), load_done, 1);
      check($sformatf("vec%0d_data", i), load_data, vecs[i].expect_val);
    end

    // Killed load does not complete and lets a store bypass.
    load_i = 1; load_invalid = 1; load_address = 12'h200;
    store_i = 1; store_address = 12'h204; store_data = 32'h0; store_width = 4'h0;
    tick();
    load_i = 0; load_invalid = 0; store_i = 0;
    check("killed_load_done", load_done, 0);
    check("killed_load_bypass_done", store_done, 1);

    // Fill the FIFO under continuous loads, then drain.
    load_i = 1; load_address = 12'h010;
    for (int k = 0; k < 4; k++) begin
      store_i = 1; store_address = 12'h020 + 12'(4 * k); store_data = 32'h10000000 + k; store_width = 4'hF;
      #1 check($sformatf("fill%0d_ready", k), store_ready, 1);
      tick();
      check($sformatf("fill%0d_load_done", k), load_done, 1);
      check($sformatf("fill%0d_load_data", k), load_data, 32'h5555AAAA);
      check($sformatf("fill%0d_no_drain", k), store_done, 0);
    end
    store_address = 12'h030; store_data = 32'h10000004;
    #1 check("full_store_ready", store_ready, 0);
    check("full_load_ready", load_ready, 1);
    tick();
    check("full_no_drain", store_done, 0);
    load_i = 0;
    #1 check("full_pop_no_push", store_ready, 0);
    tick();
    check("drain_first_done", store_done, 1);
    done_cnt = 1;
    #1 check("drain_ready_again", store_ready, 1);
    tick();
    store_i = 0;
    done_cnt += int'(store_done);
    for (int c = 0; c < 8; c++) begin
      tick();
      done_cnt += int'(store_done);
    end
    check("drain_done_count", done_cnt, 5);
    for (int k = 0; k < 5; k++) begin
      do_load(12'h020 + 12'(4 * k), rd, dn);
      check($sformatf("drain%0d_load_done", k), dn, 1);
      check($sformatf("drain%0d_data", k), rd, 32'h10000000 + k);
    end

    // Load hitting a queued store waits for it to drain.
    load_i = 1; load_address = 12'h010;
    store_i = 1; store_address = 12'h040; store_data = 32'h11223344; store_width = 4'hF;
    tick();
    store_i = 0; load_address = 12'h040;
    #1 check("hit_load_ready", load_ready, 0);
    tick();
    check("hit_stall_no_done", load_done, 0);
    check("hit_drain_done", store_done, 1);
    #1 check("hit_released", load_ready, 1);
    tick();
    load_i = 0;
    check("hit_load_done", load_done, 1);
    check("hit_load_data", load_data, 32'h11223344);

    // Two queued stores to one word: both drain in order before the load proceeds.
    load_i = 1; load_address = 12'h010;
    store_i = 1; store_address = 12'h208; store_data = 32'h11111111; store_width = 4'hF;
    tick();
    store_data = 32'h22222222;
    tick();
    store_i = 0; load_address = 12'h208;
    n = 0;
    #1;
    while (!load_ready && n < 10) begin
      tick();
      #1;
      n++;
    end
    check("order_stall_cycles", n, 2);
    tick();
    load_i = 0;
    check("order_load_done", load_done, 1);
    check("order_load_data", load_data, 32'h22222222);

    // Same-cycle load and store to one address: load sees the old word.
    load_i = 1; load_address = 12'h080;
    store_i = 1; store_address = 12'h080; store_data = 32'hA5A5A5A5; store_width = 4'hF;
    #1 check("same_load_ready", load_ready, 1);
    check("same_store_ready", store_ready, 1);
    tick();
    load_i = 0; store_i = 0;
    check("same_load_done", load_done, 1);
    check("same_old_data", load_data, 32'h12345678);
    tick();
    check("same_drain_done", store_done, 1);
    do_load(12'h080, rd, dn);
    check("same_new_done", dn, 1);
    check("same_new_data", rd, 32'hA5A5A5A5);

    // Fetch port and combinational invalidate.
    fetch_i = 1; fetch_address = 12'h000;
    tick();
    fetch_i = 0;
    check("fetch_done", fetch_done, 1);
    check("fetch_data", instruction, 32'h00C0FFEE);
    fetch_i = 1; fetch_address = 12'h100;
    tick();
    fetch_i = 0; invalidate = 1;
    #1 check("fetch_invalidated", fetch_done, 0);
    invalidate = 0;
    #1 check("fetch_not_invalidated", fetch_done, 1);
    check("fetch_data2", instruction, 32'hDEADBEEF);
    tick();
    check("fetch_done_pulse", fetch_done, 0);

    // Reset with three stores queued discards them.
    load_i = 1; load_address = 12'h010;
    for (int k = 0; k < 3; k++) begin
      store_i = 1; store_address = 12'h300 + 12'(4 * k); store_data = 32'hEE000000 + k; store_width = 4'hF;
      tick();
    end
    store_i = 0; load_i = 0; load_address = 12'h300;
    #1 check("prereset_hit", load_ready, 0);
    rst_n = 1'b0;
    #1;
    check("midreset_store_ready", store_ready, 1);
    check("midreset_load_ready", load_ready, 1);
    check("midreset_store_done", store_done, 0);
    check("midreset_load_done", load_done, 0);
    done_cnt = 0;
    repeat (2) begin
      tick();
      done_cnt += int'(store_done);
    end
    rst_n = 1'b1;
    repeat (5) begin
      tick();
      done_cnt += int'(store_done);
    end
    check("postreset_no_store_done", done_cnt, 0);
    do_load(12'h300, rd, dn);
    check("postreset_load_done", dn, 1);
    check("postreset_array_kept", rd, 32'h33333333);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
